// File: rtl/shift_frame_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : shift_frame_controller_if
// Brief    : Parallel handshake, serial pins and status for the frame controller.
// Revision : 1.0
// ============================================================================
interface shift_frame_controller_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic             si;
    logic             so;
    logic             frame;
    logic             bit_stb;
    logic [WIDTH-1:0] rx_data;
    logic             rx_valid;
    logic             busy;

    modport master (
        output tx_data, tx_valid, si,
        input  tx_ready, so, frame, bit_stb, rx_data, rx_valid, busy
    );

    modport slave (
        input  tx_data, tx_valid, si,
        output tx_ready, so, frame, bit_stb, rx_data, rx_valid, busy
    );
endinterface
`default_nettype wire

// File: rtl/shift_frame_controller.sv
`default_nettype none
// ============================================================================
// Module   : shift_frame_controller
// Brief    : Full-duplex WIDTH-bit serial frame sequencer, MSB first, DIV clk per bit.
// Revision : 1.0
// ============================================================================
module shift_frame_controller #(
    parameter int WIDTH = 8,
    parameter int DIV   = 4
) (
    input  wire logic               clk,
    input  wire logic               rst,
    shift_frame_controller_if.slave bus
);
    localparam int c_div_w = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int c_bit_w = $clog2(WIDTH);
    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(DIV - 1);
    localparam logic [c_bit_w-1:0] c_bit_last = c_bit_w'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [WIDTH-1:0]   r_sreg;
    logic [WIDTH-1:0]   r_rx_data;
    logic [WIDTH-1:0]   w_shift_next;
    logic [c_div_w-1:0] r_div_cnt;
    logic [c_bit_w-1:0] r_bit_cnt;
    logic               r_rx_valid;
    logic               w_accept;
    logic               w_bit_stb;
    logic               w_last_bit;

    assign w_shift_next = {r_sreg[WIDTH-2:0], bus.si};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_bit_stb    = 1'b0;
        w_last_bit   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_accept = bus.tx_valid;
                if (bus.tx_valid) begin
                    w_next_state = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // si is sampled on the last cycle of each bit period
                w_bit_stb  = (r_div_cnt == c_div_last);
                w_last_bit = w_bit_stb && (r_bit_cnt == c_bit_last);
                if (w_last_bit) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sreg     <= '0;
            r_div_cnt  <= '0;
            r_bit_cnt  <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            if (w_accept) begin
                r_sreg    <= bus.tx_data;
                r_div_cnt <= '0;
                r_bit_cnt <= '0;
            end else if (r_state == ST_SHIFT) begin
                if (w_bit_stb) begin
                    r_sreg    <= w_shift_next;
                    r_div_cnt <= '0;
                    r_bit_cnt <= w_last_bit ? '0 : r_bit_cnt + 1'b1;
                    if (w_last_bit) begin
                        r_rx_data  <= w_shift_next;
                        r_rx_valid <= 1'b1;
                    end
                end else begin
                    r_div_cnt <= r_div_cnt + 1'b1;
                end
            end
        end
    end

    assign bus.tx_ready = (r_state == ST_IDLE);
    assign bus.busy     = (r_state != ST_IDLE);
    assign bus.frame    = (r_state == ST_SHIFT);
    assign bus.bit_stb  = w_bit_stb;
    assign bus.so       = (r_state == ST_SHIFT) && r_sreg[WIDTH-1];
    assign bus.rx_data  = r_rx_data;
    assign bus.rx_valid = r_rx_valid;
endmodule
`default_nettype wire
